// File: rtl/address_map_pipe.sv
// SNES address decoder: maps bus addresses to SRAM0 ROM/SaveRAM addresses, flags peripheral
// window hits, tracks dirty SaveRAM blocks and counts SaveRAM writes. One-cycle registered latency.
module address_map_pipe #(
  parameter int              NUM_WIN      = 4,
  parameter int              DIRTY_BLOCKS = 16,
  parameter int              BLK_SHIFT    = 11,
  parameter logic [23:0]     SRAM_BASE    = 24'hE00000
) (
  input  logic                        CLK,
  input  logic                        RST_N,
  input  logic [23:0]                 SNES_ADDR,
  input  logic                        ADDR_VALID,
  input  logic                        SNES_WR,
  input  logic [2:0]                  CFG_MAPPER,
  input  logic [23:0]                 CFG_SAVERAM_MASK,
  input  logic [23:0]                 CFG_ROM_MASK,
  input  logic                        CFG_LD,
  input  logic [24*NUM_WIN-1:0]       WIN_BASE,
  input  logic [24*NUM_WIN-1:0]       WIN_MASK,
  input  logic [NUM_WIN-1:0]          WIN_EN,
  input  logic [DIRTY_BLOCKS-1:0]     DIRTY_CLR,
  input  logic                        CNT_CLR,
  output logic [23:0]                 ROM_ADDR,
  output logic                        ROM_HIT,
  output logic                        IS_ROM,
  output logic                        IS_SAVERAM,
  output logic                        IS_WRITABLE,
  output logic [NUM_WIN-1:0]          WIN_HIT,
  output logic                        DEC_VALID,
  output logic                        CFG_BUSY,
  output logic [DIRTY_BLOCKS-1:0]     DIRTY,
  output logic [15:0]                 WR_CNT
);

  localparam int IDX_W = $clog2(DIRTY_BLOCKS);

  // ADDR_VALID is a single-cycle strobe with no back-pressure: the decode of SNES_ADDR in
  // that cycle lands on the next edge together with a one-cycle DEC_VALID pulse.

  logic [2:0]              act_mapper_q, stg_mapper_q;
  logic [23:0]             act_sram_mask_q, stg_sram_mask_q;
  logic [23:0]             act_rom_mask_q, stg_rom_mask_q;
  logic                    busy_q;
  logic [23:0]             rom_addr_q;
  logic                    is_rom_q, is_sav_q;
  logic [NUM_WIN-1:0]      win_hit_q;
  logic                    dec_valid_q;
  logic [DIRTY_BLOCKS-1:0] dirty_q, dirty_d;
  logic [15:0]             cnt_q, cnt_d;

  logic                    map_ok, lo_map;
  logic [23:0]             rom_raw, off_hi, off_lo, dec_off, dec_addr;
  logic                    sav_hi, sav_lo, dec_sav, dec_rom, wr_sav, commit;
  logic [IDX_W-1:0]        blk_idx;
  logic [NUM_WIN-1:0]      win_d;

  always_comb begin
    map_ok = !act_mapper_q[2];
    lo_map = act_mapper_q[0];
    case (act_mapper_q[1:0])
      2'b00:   rom_raw = {1'b0, SNES_ADDR[22:0]};
      2'b01:   rom_raw = {2'b00, SNES_ADDR[22:16], SNES_ADDR[14:0]};
      2'b10:   rom_raw = {1'b0, !SNES_ADDR[23], SNES_ADDR[21:0]};
      default: rom_raw = {1'b0, !SNES_ADDR[23], SNES_ADDR[22:16], SNES_ADDR[14:0]};
    endcase
    off_hi = {6'b0, SNES_ADDR[20:16], SNES_ADDR[12:0]};
    off_lo = {4'b0, SNES_ADDR[20:16], SNES_ADDR[14:0]};
    sav_hi = act_sram_mask_q[0] & !SNES_ADDR[22] & SNES_ADDR[21] & SNES_ADDR[14]
           & SNES_ADDR[13] & !SNES_ADDR[15];
    // Upper LoROM banks 7E/7F are WRAM, hence the < 0xE bank-nibble bound.
    sav_lo = act_sram_mask_q[0] & (SNES_ADDR[22:20] == 3'b111) & (SNES_ADDR[19:16] < 4'hE)
           & (!SNES_ADDR[15] | !act_rom_mask_q[21]);
    dec_sav  = map_ok & (lo_map ? sav_lo : sav_hi);
    dec_rom  = map_ok & (SNES_ADDR[22] | SNES_ADDR[15]);
    dec_off  = (lo_map ? off_lo : off_hi) & act_sram_mask_q;
    if (!map_ok)      dec_addr = 24'h000000;
    else if (dec_sav) dec_addr = SRAM_BASE + dec_off;
    else              dec_addr = rom_raw & act_rom_mask_q;
    blk_idx = IDX_W'(dec_off >> BLK_SHIFT);
    wr_sav  = ADDR_VALID & SNES_WR & dec_sav;
    for (int i = 0; i < NUM_WIN; i++) begin
      win_d[i] = WIN_EN[i] & ((SNES_ADDR & WIN_MASK[i*24 +: 24])
                            == (WIN_BASE[i*24 +: 24] & WIN_MASK[i*24 +: 24]));
    end
  end

  // Sets win over clears so a write landing with its block's clear is never lost.
  always_comb begin
    dirty_d = dirty_q & ~DIRTY_CLR;
    if (wr_sav) dirty_d[blk_idx] = 1'b1;
    cnt_d = cnt_q;
    if (wr_sav) begin
      if (CNT_CLR)                cnt_d = 16'd1;
      else if (cnt_q != 16'hFFFF) cnt_d = cnt_q + 16'd1;
    end else if (CNT_CLR) begin
      cnt_d = 16'd0;
    end
  end

  // Commit only while no decode is sampled, so a decode always sees one consistent config.
  assign commit = busy_q & !ADDR_VALID;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      act_mapper_q    <= 3'b000;
      act_sram_mask_q <= 24'h0;
      act_rom_mask_q  <= 24'h0;
      stg_mapper_q    <= 3'b000;
      stg_sram_mask_q <= 24'h0;
      stg_rom_mask_q  <= 24'h0;
      busy_q          <= 1'b0;
    end else begin
      if (commit) begin
        act_mapper_q    <= stg_mapper_q;
        act_sram_mask_q <= stg_sram_mask_q;
        act_rom_mask_q  <= stg_rom_mask_q;
      end
      if (CFG_LD) begin
        stg_mapper_q    <= CFG_MAPPER;
        stg_sram_mask_q <= CFG_SAVERAM_MASK;
        stg_rom_mask_q  <= CFG_ROM_MASK;
        busy_q          <= 1'b1;
      end else if (commit) begin
        busy_q          <= 1'b0;
      end
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      rom_addr_q  <= 24'h0;
      is_rom_q    <= 1'b0;
      is_sav_q    <= 1'b0;
      win_hit_q   <= '0;
      dec_valid_q <= 1'b0;
      dirty_q     <= '0;
      cnt_q       <= 16'h0;
    end else begin
      dec_valid_q <= ADDR_VALID;
      if (ADDR_VALID) begin
        rom_addr_q <= dec_addr;
        is_rom_q   <= dec_rom;
        is_sav_q   <= dec_sav;
        win_hit_q  <= win_d;
      end
      dirty_q <= dirty_d;
      cnt_q   <= cnt_d;
    end
  end

  assign ROM_ADDR    = rom_addr_q;
  assign IS_ROM      = is_rom_q;
  assign IS_SAVERAM  = is_sav_q;
  assign IS_WRITABLE = is_sav_q;
  assign ROM_HIT     = is_rom_q | is_sav_q;
  assign WIN_HIT     = win_hit_q;
  assign DEC_VALID   = dec_valid_q;
  assign CFG_BUSY    = busy_q;
  assign DIRTY       = dirty_q;
  assign WR_CNT      = cnt_q;

endmodule

// File: tb/tb_address_map_pipe.sv
// Directed bench for address_map_pipe: hand-computed decode, config staging, dirty/counter
// and reset vectors, each checked with an immediate assertion.
module tb_address_map_pipe;
  localparam int NUM_WIN = 4;
  localparam int DB      = 16;

  logic              CLK, RST_N;
  logic [23:0]       SNES_ADDR;
  logic              ADDR_VALID, SNES_WR;
  logic [2:0]        CFG_MAPPER;
  logic [23:0]       CFG_SAVERAM_MASK, CFG_ROM_MASK;
  logic              CFG_LD;
  logic [24*NUM_WIN-1:0] WIN_BASE, WIN_MASK;
  logic [NUM_WIN-1:0] WIN_EN;
  logic [DB-1:0]     DIRTY_CLR;
  logic              CNT_CLR;
  logic [23:0]       ROM_ADDR;
  logic              ROM_HIT, IS_ROM, IS_SAVERAM, IS_WRITABLE;
  logic [NUM_WIN-1:0] WIN_HIT;
  logic              DEC_VALID, CFG_BUSY;
  logic [DB-1:0]     DIRTY;
  logic [15:0]       WR_CNT;

  int pass_cnt = 0;
  int fail_cnt = 0;
  int total_cnt = 0;

  address_map_pipe #(.NUM_WIN(NUM_WIN), .DIRTY_BLOCKS(DB), .BLK_SHIFT(11),
                     .SRAM_BASE(24'hE00000)) dut (
    .CLK(CLK), .RST_N(RST_N), .SNES_ADDR(SNES_ADDR), .ADDR_VALID(ADDR_VALID),
    .SNES_WR(SNES_WR), .CFG_MAPPER(CFG_MAPPER), .CFG_SAVERAM_MASK(CFG_SAVERAM_MASK),
    .CFG_ROM_MASK(CFG_ROM_MASK), .CFG_LD(CFG_LD), .WIN_BASE(WIN_BASE), .WIN_MASK(WIN_MASK),
    .WIN_EN(WIN_EN), .DIRTY_CLR(DIRTY_CLR), .CNT_CLR(CNT_CLR), .ROM_ADDR(ROM_ADDR),
    .ROM_HIT(ROM_HIT), .IS_ROM(IS_ROM), .IS_SAVERAM(IS_SAVERAM), .IS_WRITABLE(IS_WRITABLE),
    .WIN_HIT(WIN_HIT), .DEC_VALID(DEC_VALID), .CFG_BUSY(CFG_BUSY), .DIRTY(DIRTY),
    .WR_CNT(WR_CNT)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else begin
      fail_cnt++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic decode(input logic [23:0] a, input logic wr);
    SNES_ADDR = a; SNES_WR = wr; ADDR_VALID = 1'b1;
    tick();
    ADDR_VALID = 1'b0; SNES_WR = 1'b0;
  endtask

  task automatic load_cfg(input logic [2:0] m, input logic [23:0] sm, input logic [23:0] rm);
    CFG_MAPPER = m; CFG_SAVERAM_MASK = sm; CFG_ROM_MASK = rm; CFG_LD = 1'b1;
    tick();
    CFG_LD = 1'b0;
    check("cfg_busy_set", 32'(CFG_BUSY), 32'h1);
    tick();
    check("cfg_busy_clr", 32'(CFG_BUSY), 32'h0);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_addr"}, 32'(ROM_ADDR), 32'h0);
    check({tag, "_flags"}, {28'h0, ROM_HIT, IS_ROM, IS_SAVERAM, IS_WRITABLE}, 32'h0);
    check({tag, "_win"}, 32'(WIN_HIT), 32'h0);
    check({tag, "_dv_busy"}, {30'h0, DEC_VALID, CFG_BUSY}, 32'h0);
    check({tag, "_dirty"}, 32'(DIRTY), 32'h0);
    check({tag, "_cnt"}, 32'(WR_CNT), 32'h0);
  endtask

  initial begin
    RST_N = 1'b0; SNES_ADDR = '0; ADDR_VALID = 1'b0; SNES_WR = 1'b0;
    CFG_MAPPER = '0; CFG_SAVERAM_MASK = '0; CFG_ROM_MASK = '0; CFG_LD = 1'b0;
    WIN_BASE = '0; WIN_MASK = '0; WIN_EN = '0; DIRTY_CLR = '0; CNT_CLR = 1'b0;
    #12;
    check_all_zero("reset");
    RST_N = 1'b1;
    tick();

    // Reset config: mapper 000, ROM mask 0 -> ROM flag set, address masked to 0
    decode(24'hC12345, 1'b0);
    check("rstcfg_addr", 32'(ROM_ADDR), 32'h000000);
    check("rstcfg_isrom", 32'(IS_ROM), 32'h1);

    load_cfg(3'b000, 24'h007FFF, 24'h3FFFFF);
    decode(24'hC12345, 1'b0);
    check("hirom_addr", 32'(ROM_ADDR), 32'h012345);
    check("hirom_flags", {28'h0, ROM_HIT, IS_ROM, IS_SAVERAM, IS_WRITABLE}, 32'hC);
    check("hirom_dv", 32'(DEC_VALID), 32'h1);
    tick();
    check("dv_pulse_end", 32'(DEC_VALID), 32'h0);
    check("hold_addr", 32'(ROM_ADDR), 32'h012345);

    decode(24'h306123, 1'b0);
    check("hisav_addr", 32'(ROM_ADDR), 32'hE00123);
    check("hisav_flags", {28'h0, ROM_HIT, IS_ROM, IS_SAVERAM, IS_WRITABLE}, 32'hB);

    // Config load inside a back-to-back burst: burst keeps mapper 000
    SNES_ADDR = 24'hC12345; ADDR_VALID = 1'b1;
    CFG_MAPPER = 3'b001; CFG_SAVERAM_MASK = 24'h007FFF; CFG_ROM_MASK = 24'h3FFFFF; CFG_LD = 1'b1;
    tick();
    CFG_LD = 1'b0;
    check("burst1_addr", 32'(ROM_ADDR), 32'h012345);
    check("burst1_busy", 32'(CFG_BUSY), 32'h1);
    SNES_ADDR = 24'h701234;
    tick();
    check("burst2_addr", 32'(ROM_ADDR), 32'h301234);
    check("burst2_sav", 32'(IS_SAVERAM), 32'h0);
    check("burst2_busy", 32'(CFG_BUSY), 32'h1);
    ADDR_VALID = 1'b0;
    tick();
    check("burst_commit", 32'(CFG_BUSY), 32'h0);

    decode(24'h701234, 1'b0);
    check("losav_addr", 32'(ROM_ADDR), 32'hE01234);
    check("losav_sav", 32'(IS_SAVERAM), 32'h1);
    check("losav_dv", 32'(DEC_VALID), 32'h1);
    check("losav_rdcnt", 32'(WR_CNT), 32'h0);
    decode(24'h818123, 1'b0);
    check("lorom_addr", 32'(ROM_ADDR), 32'h008123);
    check("lorom_flags", {28'h0, ROM_HIT, IS_ROM, IS_SAVERAM, IS_WRITABLE}, 32'hC);

    // Dirty tracking and write counter
    decode(24'h700800, 1'b1);
    check("wr1_dirty", 32'(DIRTY), 32'h0002);
    check("wr1_cnt", 32'(WR_CNT), 32'h1);
    DIRTY_CLR = 16'h0002;
    decode(24'h700800, 1'b1);
    DIRTY_CLR = '0;
    check("wr2_dirty", 32'(DIRTY), 32'h0002);
    check("wr2_cnt", 32'(WR_CNT), 32'h2);
    DIRTY_CLR = 16'h0002;
    tick();
    DIRTY_CLR = '0;
    check("clr_dirty", 32'(DIRTY), 32'h0000);
    decode(24'h818123, 1'b1);
    check("romwr_dirty", 32'(DIRTY), 32'h0000);
    check("romwr_cnt", 32'(WR_CNT), 32'h2);
    decode(24'h701000, 1'b1);
    check("wr3_dirty", 32'(DIRTY), 32'h0004);
    check("wr3_cnt", 32'(WR_CNT), 32'h3);
    CNT_CLR = 1'b1;
    decode(24'h701000, 1'b1);
    CNT_CLR = 1'b0;
    check("clrinc_cnt", 32'(WR_CNT), 32'h1);
    CNT_CLR = 1'b1;
    tick();
    CNT_CLR = 1'b0;
    check("clr_cnt", 32'(WR_CNT), 32'h0);

    // Peripheral windows
    WIN_BASE[23:0] = 24'h002000; WIN_MASK[23:0] = 24'hFFFFF8;
    WIN_BASE[47:24] = 24'h7F0000; WIN_MASK[47:24] = 24'hFF0000;
    WIN_EN = 4'b0001;
    decode(24'h002007, 1'b0);
    check("win0_hit", 32'(WIN_HIT), 32'h1);
    decode(24'h002008, 1'b0);
    check("win0_miss", 32'(WIN_HIT), 32'h0);
    decode(24'h7F1234, 1'b0);
    check("win1_dis", 32'(WIN_HIT), 32'h0);
    WIN_EN = 4'b0011;
    decode(24'h7F1234, 1'b0);
    check("win1_hit", 32'(WIN_HIT), 32'h2);

    // Counter saturation via a long back-to-back write burst
    SNES_ADDR = 24'h700800; SNES_WR = 1'b1; ADDR_VALID = 1'b1;
    repeat (65535) tick();
    ADDR_VALID = 1'b0; SNES_WR = 1'b0;
    check("sat_reach", 32'(WR_CNT), 32'hFFFF);
    decode(24'h700800, 1'b1);
    check("sat_hold", 32'(WR_CNT), 32'hFFFF);

    // Unmapped mapper
    load_cfg(3'b100, 24'h007FFF, 24'h3FFFFF);
    decode(24'h701234, 1'b1);
    check("unmap_addr", 32'(ROM_ADDR), 32'h0);
    check("unmap_flags", {28'h0, ROM_HIT, IS_ROM, IS_SAVERAM, IS_WRITABLE}, 32'h0);
    check("unmap_cnt", 32'(WR_CNT), 32'hFFFF);

    // Asynchronous reset mid-burst with a staged config pending
    load_cfg(3'b001, 24'h007FFF, 24'h3FFFFF);
    SNES_ADDR = 24'h700800; SNES_WR = 1'b1; ADDR_VALID = 1'b1;
    CFG_MAPPER = 3'b010; CFG_LD = 1'b1;
    tick();
    CFG_LD = 1'b0;
    check("pre_rst_busy", 32'(CFG_BUSY), 32'h1);
    #2 RST_N = 1'b0;
    #1;
    check_all_zero("async_rst");
    ADDR_VALID = 1'b0; SNES_WR = 1'b0;
    #3 RST_N = 1'b1;
    tick();
    check("post_rst_busy", 32'(CFG_BUSY), 32'h0);
    decode(24'hC12345, 1'b0);
    check("post_rst_addr", 32'(ROM_ADDR), 32'h0);
    check("post_rst_rom", 32'(IS_ROM), 32'h1);
    check("post_rst_dv", 32'(DEC_VALID), 32'h1);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule

// File: doc/address_map_pipe.md
ADDRESS_MAP_PIPE -- requirements
Module: address_map_pipe

Interface
REQ-001 SHALL have parameter NUM_WIN, default 4, meaning number of programmable peripheral address windows (1..8).
REQ-002 SHALL have parameter DIRTY_BLOCKS, default 16, meaning number of SaveRAM dirty-tracking blocks (power of two, 2..64).
REQ-003 SHALL have parameter BLK_SHIFT, default 11, meaning log2 of dirty-block size in bytes.
REQ-004 SHALL have parameter SRAM_BASE, default 24'hE00000, meaning SaveRAM base in the SRAM0 address space.
REQ-005 SHALL have ports (name  direction  width  meaning):
  CLK  in  1  system clock;
  RST_N  in  1  reset, asynchronous, active-low;
  SNES_ADDR  in  24  SNES bus address;
  ADDR_VALID  in  1  one-cycle pulse, SNES_ADDR stable and to be decoded;
  SNES_WR  in  1  qualifies ADDR_VALID as a write;
  CFG_MAPPER  in  3  staged mapper select;
  CFG_SAVERAM_MASK  in  24  staged SaveRAM mask;
  CFG_ROM_MASK  in  24  staged ROM mask;
  CFG_LD  in  1  pulse, stage CFG_* for commit;
  WIN_BASE  in  24*NUM_WIN  window base addresses, packed;
  WIN_MASK  in  24*NUM_WIN  window compare masks, packed;
  WIN_EN  in  NUM_WIN  window enables;
  DIRTY_CLR  in  DIRTY_BLOCKS  per-block dirty clear pulses;
  CNT_CLR  in  1  pulse, clear write counter;
  ROM_ADDR  out  24  registered SRAM0 address;
  ROM_HIT, IS_ROM, IS_SAVERAM, IS_WRITABLE  out  1 each  registered decode flags;
  WIN_HIT  out  NUM_WIN  registered window hits;
  DEC_VALID  out  1  pulse, decode outputs updated;
  CFG_BUSY  out  1  staged config not yet committed;
  DIRTY  out  DIRTY_BLOCKS  SaveRAM block dirty flags;
  WR_CNT  out  16  SaveRAM write counter.

Function
REQ-006 SHALL register all decode outputs; DEC_VALID SHALL assert exactly 1 cycle after ADDR_VALID, for 1 cycle; outputs SHALL hold between decodes.
REQ-007 SHALL decode mappers from active config: 000 HiROM, 001 LoROM, 010 ExHiROM, 011 ExLoROM; 100-111 SHALL yield ROM_ADDR=0 and all flags 0.
REQ-008 IS_ROM SHALL be (A22 | A15) for mappers 000-011.
REQ-009 HiROM/ExHiROM IS_SAVERAM SHALL be SRAM_MASK[0] & !A22 & A21 & A14 & A13 & !A15; offset = {A20:16, A12:0} & SRAM mask.
REQ-010 LoROM/ExLoROM IS_SAVERAM SHALL be SRAM_MASK[0] & A22:20==111 & A19:16<1110 & (!A15 | !ROM_MASK[21]); offset = {A20:16, A14:0} & SRAM mask.
REQ-011 SaveRAM ROM_ADDR SHALL be SRAM_BASE + offset, 24-bit, carry discarded.
REQ-012 ROM ROM_ADDR SHALL be, & ROM mask: HiROM {0,A22:0}; LoROM {00,A22:16,A14:0}; ExHiROM {0,!A23,A21:0}; ExLoROM {0,!A23,A22:16,A14:0}.
REQ-013 IS_WRITABLE SHALL equal IS_SAVERAM; ROM_HIT SHALL equal IS_ROM | IS_WRITABLE.
REQ-014 WIN_HIT[i] SHALL be WIN_EN[i] & ((SNES_ADDR & mask_i) == (base_i & mask_i)), independent of mapper.
REQ-015 CFG_LD SHALL capture CFG_* into a staging register and set CFG_BUSY next cycle.
REQ-016 Staged config SHALL commit in the first cycle with ADDR_VALID low and no decode pending; CFG_BUSY SHALL clear same edge; a decode SHALL never mix old and new config.
REQ-017 CFG_LD while CFG_BUSY SHALL overwrite staging (last wins); CFG_LD coincident with ADDR_VALID SHALL not affect that decode.
REQ-018 ADDR_VALID & SNES_WR & IS_SAVERAM (current decode) SHALL set DIRTY[(offset >> BLK_SHIFT) mod DIRTY_BLOCKS] and increment WR_CNT, both visible with DEC_VALID.
REQ-019 WR_CNT SHALL saturate at 16'hFFFF; CNT_CLR coincident with increment SHALL yield 1.
REQ-020 DIRTY_CLR[i] coincident with a set of bit i SHALL leave bit i set.
REQ-021 Writes to ROM or unmapped addresses SHALL not alter DIRTY or WR_CNT.

Reset
REQ-022 RST_N low SHALL asynchronously clear ROM_ADDR, all flags, WIN_HIT, DEC_VALID, CFG_BUSY, DIRTY, WR_CNT, staging; active config SHALL reset to mapper 000, both masks 0.
REQ-023 Reset mid-decode or with CFG_BUSY SHALL discard pending work; first ADDR_VALID after deassertion SHALL decode normally.

Verification
REQ-024 Mapper 001, masks ROM 3FFFFF/SRAM 007FFF, A=70_1234 read -> next cycle IS_SAVERAM=1, ROM_ADDR=E01234, DEC_VALID=1.
REQ-025 Mapper 000, A=C1_2345, ROM mask 3FFFFF -> IS_ROM=1, IS_SAVERAM=0, ROM_ADDR=012345.
REQ-026 CFG_LD to mapper 001 during back-to-back ADDR_VALID -> CFG_BUSY=1, in-burst decodes use mapper 000, commit on first idle cycle.
REQ-027 Mapper 001, SRAM mask 7FFF, write 70_0800 -> DIRTY[1]=1, WR_CNT=1; DIRTY_CLR[1] with second write there -> DIRTY[1]=1, WR_CNT=2.
REQ-028 WIN0 base 002000 mask FFFFF8 en, A=002007 -> WIN_HIT[0]=1; A=002008 -> 0.
REQ-029 WR_CNT=FFFF plus SaveRAM write -> stays FFFF; RST_N pulse mid-burst -> all outputs 0 asynchronously.
